// File: rtl/sev_pkg.sv
// Shared codes and types for the seven-segment scan driver.
// Codes are the decoder's input alphabet.
package sev_pkg;

    localparam logic [7:0] CODE_DASH  = 8'h0A;
    localparam logic [7:0] CODE_BLANK = 8'h0B;
    localparam logic [7:0] CODE_UNDER = 8'h0C;

    typedef logic [3:0] digit_code_t;
    typedef digit_code_t [3:0] disp_word_t;

    function automatic logic [3:0] an_sel_n(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/sev_slot_timer.sv
// Per-digit slot counter and digit index for the scan driver.
// Emits the frame-boundary and blanking strobes from current count state.
module sev_slot_timer #(
    parameter int SLOT      = 16,
    parameter int BLANK_CYC = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [1:0] digit_idx,
    output logic       frame_boundary,
    output logic       in_blank
);

    localparam int CW = (SLOT > 2) ? $clog2(SLOT) : 1;
    localparam logic [CW-1:0] LAST = CW'(SLOT - 1);
    localparam logic [CW-1:0] BLK  = CW'(BLANK_CYC);

    logic [CW-1:0] cnt;
    logic          wrap;

    assign wrap           = (cnt == LAST);
    assign frame_boundary = wrap && (digit_idx == 2'd3);
    assign in_blank       = (cnt < BLK);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            digit_idx <= 2'd0;
        end else if (wrap) begin
            cnt       <= '0;
            digit_idx <= digit_idx + 2'd1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/sev_scan.sv
// Time-multiplexed scan driver for a 4-digit common-anode display.
// New values are buffered and applied only at frame boundaries.
module sev_scan
    import sev_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int REFRESH_HZ = 1000,
    parameter int BLANK_CYC  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_digits,
    input  logic [3:0]  in_dp_mask,
    output logic [7:0]  code,
    output logic [3:0]  an,
    output logic        dp,
    output logic [1:0]  digit_idx
);

    localparam int SLOT = CLK_HZ / REFRESH_HZ;
    localparam digit_code_t DASH = CODE_DASH[3:0];

    if (SLOT < 2 * BLANK_CYC) begin : g_bad_slot
        $error("sev_scan: SLOT must be at least 2*BLANK_CYC");
    end

    logic [1:0] idx;
    logic       boundary;
    logic       blank;
    logic       take;

    disp_word_t disp;
    disp_word_t pbuf;
    logic [3:0] dpm;
    logic [3:0] pdpm;
    logic       pending;

    sev_slot_timer #(
        .SLOT      (SLOT),
        .BLANK_CYC (BLANK_CYC)
    ) u_timer (
        .clk            (clk),
        .rst_n          (rst_n),
        .digit_idx      (idx),
        .frame_boundary (boundary),
        .in_blank       (blank)
    );

    assign take = in_valid && in_ready;

    // Transfer and apply are exclusive: a transfer needs pending=0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending  <= 1'b0;
            in_ready <= 1'b1;
            pbuf     <= '0;
            pdpm     <= 4'h0;
            disp     <= {4{DASH}};
            dpm      <= 4'h0;
        end else if (take) begin
            pbuf     <= in_digits;
            pdpm     <= in_dp_mask;
            pending  <= 1'b1;
            in_ready <= 1'b0;
        end else if (pending && boundary) begin
            disp     <= pbuf;
            dpm      <= pdpm;
            pending  <= 1'b0;
            in_ready <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an        <= 4'hF;
            code      <= CODE_BLANK;
            dp        <= 1'b1;
            digit_idx <= 2'd0;
        end else begin
            digit_idx <= idx;
            if (blank) begin
                an   <= 4'hF;
                code <= CODE_BLANK;
                dp   <= 1'b1;
            end else begin
                an   <= an_sel_n(idx);
                code <= {4'h0, disp[idx]};
                dp   <= ~dpm[idx];
            end
        end
    end

endmodule

// File: tb/tb_sev_scan.sv
// Scoreboard bench for sev_scan with a time-based reference model.
// SLOT=16 cycles, frame=64 cycles.
module tb_sev_scan;

    localparam int CLK_HZ     = 64;
    localparam int REFRESH_HZ = 4;
    localparam int BLANK_CYC  = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_digits = 16'h0;
    logic [3:0]  in_dp_mask = 4'h0;
    logic [7:0]  code;
    logic [3:0]  an;
    logic        dp;
    logic [1:0]  digit_idx;

    sev_scan #(
        .CLK_HZ     (CLK_HZ),
        .REFRESH_HZ (REFRESH_HZ),
        .BLANK_CYC  (BLANK_CYC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_digits  (in_digits),
        .in_dp_mask (in_dp_mask),
        .code       (code),
        .an         (an),
        .dp         (dp),
        .digit_idx  (digit_idx)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] an;
        logic [7:0] code;
        logic       dp;
        logic [1:0] idx;
        logic       rdy;
    } obs_t;

    localparam obs_t RST = '{an: 4'hF, code: 8'h0B, dp: 1'b1,
                             idx: 2'd0, rdy: 1'b1};

    obs_t expq[$];
    int checks = 0;
    int errors = 0;

    // Model: edge index since reset release decides slot and phase.
    int          mt = 0;
    logic [15:0] m_disp = 16'hAAAA;
    logic [3:0]  m_dpm = 4'h0;
    logic [15:0] m_pbuf = 16'h0;
    logic [3:0]  m_pdpm = 4'h0;
    bit          m_pend = 1'b0;

    initial begin
        int   c;
        int   k;
        bit   blank;
        bit   pre;
        obs_t e;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                mt = 0;
                m_disp = 16'hAAAA;
                m_dpm = 4'h0;
                m_pend = 1'b0;
            end else begin
                c = mt % 16;
                k = (mt / 16) % 4;
                blank = (c < BLANK_CYC);
                e.an   = blank ? 4'hF : (4'hF ^ (4'h1 << k));
                e.code = blank ? 8'h0B : {4'h0, m_disp[k*4 +: 4]};
                e.dp   = blank ? 1'b1 : ~m_dpm[k];
                e.idx  = 2'(k);
                pre = m_pend;
                if (pre && (mt % 64) == 63) begin
                    m_disp = m_pbuf;
                    m_dpm = m_pdpm;
                    m_pend = 1'b0;
                end
                if (!pre && in_valid) begin
                    m_pbuf = in_digits;
                    m_pdpm = in_dp_mask;
                    m_pend = 1'b1;
                end
                e.rdy = !m_pend;
                expq.push_back(e);
                mt++;
            end
        end
    end

    initial begin
        obs_t act;
        obs_t ex;
        forever begin
            @(negedge clk);
            act = {an, code, dp, digit_idx, in_ready};
            if (!rst_n) begin
                ex = RST;
                expq.delete();
            end else if (expq.size() == 0) begin
                ex = RST;
            end else begin
                ex = expq.pop_front();
            end
            checks++;
            if (act !== ex) begin
                errors++;
                $display("FAIL scan t=%0t an=%b exp %b code=%h exp %h dp=%b exp %b idx=%0d exp %0d rdy=%b exp %b",
                         $time, act.an, ex.an, act.code, ex.code, act.dp,
                         ex.dp, act.idx, ex.idx, act.rdy, ex.rdy);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [15:0] d, input logic [3:0] m,
                        input int hold_max, output bit done);
        bit r;
        int waited;
        done = 1'b0;
        waited = 0;
        in_valid = 1'b1;
        in_digits = d;
        in_dp_mask = m;
        while (!done && waited < hold_max) begin
            @(negedge clk);
            r = in_ready;
            @(posedge clk);
            #2;
            if (r) done = 1'b1;
            waited++;
        end
        in_valid = 1'b0;
    endtask

    task automatic send_must(input logic [15:0] d, input logic [3:0] m);
        bit done;
        send(d, m, 300, done);
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL handshake value=%h accepted=%b required 1", d, done);
        end
    endtask

    task automatic wait_phase(input int p);
        for (int i = 0; i < 200 && (mt % 64) != p; i++) tick(1);
        checks++;
        if ((mt % 64) != p) begin
            errors++;
            $display("FAIL wait_phase got %0d required %0d", mt % 64, p);
        end
    endtask

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog time=%0t", $time);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        bit done;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        tick(80);

        wait_phase(20);
        send_must(16'h4321, 4'b0010);
        send_must(16'h9999, 4'b0000);
        tick(140);

        wait_phase(63);
        in_valid = 1'b1;
        in_digits = 16'h5678;
        in_dp_mask = 4'b1000;
        tick(1);
        in_valid = 1'b0;
        tick(150);

        wait_phase(1);
        send_must(16'h1357, 4'b0100);
        wait_phase(40);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (an !== 4'hF || code !== 8'h0B) begin
            errors++;
            $display("FAIL async_reset an=%b code=%h required 1111/0b", an, code);
        end
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        tick(140);

        send_must(16'hFCB0, 4'b0000);
        tick(140);

        repeat (12) begin
            tick($urandom_range(0, 40));
            if ($urandom_range(0, 3) == 0)
                send(16'($urandom), 4'($urandom), $urandom_range(1, 3), done);
            else
                send_must(16'($urandom), 4'($urandom));
        end
        tick(140);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sev_scan.md
Name: sev_scan

Overview:
- Time-multiplexed scan driver for the board's 4-digit common-anode seven-segment display.
- Sits directly upstream of the seven-segment decoder and drives its 8-bit code input. The decoder turns `code` into segments a..g.
- Accepts a new 4-digit value through a valid/ready handshake and cycles the anodes at a fixed refresh rate.
- Blanks briefly between digits to suppress ghosting, and applies new values only at frame boundaries so a frame never tears.

Parameters:
- CLK_HZ, 100_000_000, system clock frequency in Hz.
- REFRESH_HZ, 1000, per-digit slot rate in Hz. SLOT = CLK_HZ/REFRESH_HZ cycles per digit; elaboration error if SLOT < 2*BLANK_CYC.
- BLANK_CYC, 16, cycles at the start of each slot with all anodes off.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  producer has a new display value.
- in_ready  out  1  block can accept a value.
- in_digits  in  16  four 4-bit codes; [3:0]=digit0 (rightmost) .. [15:12]=digit3.
- in_dp_mask  in  4  decimal-point enable per digit, 1=lit.
- code  out  8  decoder input; the 4-bit digit code zero-extended, or CODE_BLANK.
- an  out  4  anode enables, active-low, at most one bit low.
- dp  out  1  decimal point, active-low.
- digit_idx  out  2  index of the digit currently being scanned.

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst_n` is asynchronous and active-low.
- Reset values:
  - an=4'b1111, code=CODE_BLANK (8'h0B), dp=1, digit_idx=0, in_ready=1.
  - Slot counter=0, pending flag=0.
  - Display registers = CODE_DASH (4'hA) on all digits, dp_mask=0.
- Slot counter:
  - Counts 0..SLOT-1, then wraps to 0.
  - On wrap, digit_idx increments modulo 4.
  - Frame boundary = the cycle in which the slot counter is SLOT-1 and digit_idx is 3.
- Per-slot phases:
  - BLANK (count < BLANK_CYC): an=4'b1111, code=CODE_BLANK, dp=1.
  - SHOW (count >= BLANK_CYC): an=~(4'b0001<<digit_idx), code={4'h0, disp[digit_idx]}, dp=~dp_mask[digit_idx].
- Output timing: all outputs are registered and reflect the counter state of the previous cycle, so there is one cycle of latency from counter to pins.
- Handshake:
  - A transfer occurs when in_valid && in_ready on a rising edge.
  - in_digits and in_dp_mask are captured into a pending buffer and the pending flag is set.
  - in_ready = !pending, registered.
  - The producer holds data stable while in_valid=1 and in_ready=0. in_valid may drop without a transfer.
- Apply:
  - At a frame boundary with pending=1, the display registers load the pending buffer and pending clears.
  - in_ready returns to 1 on the next cycle.
  - The new value first appears in digit0's SHOW phase of the next frame.
- Transfer on a frame-boundary cycle with pending=0: the value is buffered only and applies at the following boundary. Worst-case apply latency is 4*SLOT+1 cycles.
- in_valid while pending=1: no capture; the pending buffer is unchanged.
- Reset mid-frame: all state returns immediately to reset values and the pending value is discarded. Scanning restarts at digit0 BLANK after release.
- Code width: codes above 4'hC pass through unchanged. The decoder shows them blank.

Decomposition:
- Package sev_pkg holds:
  - CODE_DASH=8'h0A, CODE_BLANK=8'h0B, CODE_UNDER=8'h0C.
  - The typedef digit_code_t (logic [3:0]).
  - The typedef disp_word_t (digit_code_t [3:0]).
- One sub-module, sev_slot_timer: the slot counter, digit_idx, and the frame_boundary and in_blank strobes.
- Handshake, buffers and output registers stay in sev_scan.

Test Plan (CLK_HZ=64, REFRESH_HZ=4, BLANK_CYC=2, so SLOT=16 and frame=64 cycles):
- Release reset, no input:
  - an walks 1110,1101,1011,0111 every 16 cycles.
  - Cycles 0-1 of each slot show an=1111 and code=8'h0B; otherwise code=8'h0A and dp=1.
- Send 16'h4321 with dp_mask=4'b0010 mid-frame:
  - in_ready drops the next cycle.
  - From the next digit0 SHOW phase onward, code=01,02,03,04; dp=0 only while an=1101.
  - in_ready rises the cycle after the boundary.
- Hold in_valid with 16'h9999 while pending:
  - No capture; the earlier value displays.
  - 16'h9999 is accepted only after in_ready returns, and displays one frame later.
- Transfer on an exact frame-boundary cycle with pending=0: the value is not shown in the immediately following frame, only in the one after.
- Assert rst_n low during digit2 SHOW with pending=1:
  - an=1111 and code=0B asynchronously.
  - After release, dashes display and the pending value never appears.
- Send in_digits=16'hFCB0: digit0 code=00, digit1=0B, digit2=0C, digit3=0F, all zero-extended.
